// File: rtl/handshake_pkg.sv
// handshake_pkg
//   Definitions shared by every endpoint of the valid/ready/data handshake
//   channel: the behavioural master/slave models and the synthesizable
//   receive buffer all use the same beat counter width and fire condition.
//
//   BEAT_CNT_BITS : width of the running accepted-beat counter
//   hs_fire()     : a beat moves across the link on this edge
package handshake_pkg;

    localparam int BEAT_CNT_BITS = 32;

    function automatic logic hs_fire(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core
//   Plain synchronous first-word-fall-through FIFO. Knows nothing about the
//   handshake protocol; the caller decides when to push and pop.
//
//   clk    in   single clock, rising edge
//   rst    in   synchronous active-high reset (pointers and count only)
//   push   in   write wdata at the tail (ignored when full)
//   wdata  in   WIDTH-bit entry to write
//   pop    in   drop the head entry (ignored when empty)
//   rdata  out  head entry, combinational from storage
//   count  out  entries currently held
//   full   out  count == DEPTH
//   empty  out  count == 0
module sync_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty are decoded from the count so that the pointers are free
    // to wrap without needing an extra lap bit.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];

    // Next-state pointers and occupancy. DEPTH is a power of two, so the
    // natural overflow of the PTR_W-bit add is the DEPTH-1 -> 0 wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; stale entries are never
    // visible because rd_valid is derived from the count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/handshake_rx_buffer.sv
// handshake_rx_buffer
//   Receiving endpoint of the valid/ready/data handshake link. Accepted beats
//   land in a FWFT FIFO that local logic drains through the rd_* pop port.
//
//   clk         in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   valid       in   master presents a beat on data
//   ready       out  a beat offered this cycle is taken
//   data        in   beat payload
//   rd_en       in   pop the head entry
//   rd_valid    out  FIFO holds at least one entry
//   rd_data     out  head entry
//   count       out  entries held
//   overflow    out  sticky: a beat was discarded (ALWAYS_READY=1 only)
//   beat_count  out  accepted beats, wraps modulo 2^32
module handshake_rx_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 4,
    parameter int ALWAYS_READY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    output logic                         ready,
    input  logic [DATA_BITS-1:0]         data,
    input  logic                         rd_en,
    output logic                         rd_valid,
    output logic [DATA_BITS-1:0]         rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic [BEAT_CNT_BITS-1:0]     beat_count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $fatal(1, "handshake_rx_buffer: DEPTH must be a power of two and >= 2");
    end

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fire;
    logic                     push;
    logic                     overflow_q, overflow_d;
    logic [BEAT_CNT_BITS-1:0] beat_count_q, beat_count_d;

    // Ready comes only from reset and registered occupancy, never from
    // rd_en, so a full buffer refuses a beat even if it pops that cycle.
    always_comb begin
        if (ALWAYS_READY != 0) begin
            ready = !rst;
        end else begin
            ready = !rst && !fifo_full;
        end
    end

    // In always-ready mode a beat can fire while full; it is dropped rather
    // than stored, and that is what the overflow flag records.
    assign fire = hs_fire(valid, ready);
    assign push = fire && !fifo_full;

    always_comb begin
        overflow_d   = overflow_q | (fire && fifo_full);
        beat_count_d = beat_count_q + BEAT_CNT_BITS'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            beat_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            beat_count_q <= beat_count_d;
        end
    end

    sync_fifo_core #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (data),
        .pop   (rd_en),
        .rdata (rd_data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rd_valid   = !fifo_empty;
    assign overflow   = overflow_q;
    assign beat_count = beat_count_q;

endmodule
